chaser_tick_gen: RTL
====================

// Module: chaser_tick_gen
// PURPOSE
//  Upstream stage of the 5-LED chaser. Divides the board oscillator down to the slow
//  clock that advances the chaser counter, plus a one-cycle tick strobe.
//  Two debounced push-buttons are supported: pause/resume, and single-step while paused.
//  slow_clk drives the chaser's clk input directly.
// PARAMETERS
//  CLK_HZ       2_080_000  input clock frequency in Hz
//  OUT_HZ       1          slow_clk frequency in Hz while running
//  DEBOUNCE_MS  20         button stable time in ms
//  Derived: HALF = CLK_HZ/(2*OUT_HZ), which must be >= 2.
//  Derived: DB_CYCLES = (CLK_HZ/1000)*DEBOUNCE_MS, which must be >= 1.
//  Counter widths are $clog2 of each derived value, minimum 1.
// PORTS
//  clk          in   1  oscillator clock; all logic is on its posedge
//  rst_n        in   1  asynchronous, active-low reset
//  btn_pause_n  in   1  pause/resume button, active-low, asynchronous to clk
//  btn_step_n   in   1  single-step button, active-low, asynchronous to clk
//  slow_clk     out  1  divided square wave that feeds the chaser clk
//  tick         out  1  one-cycle strobe in the cycle slow_clk becomes 1
//  running      out  1  1 in state RUN, 0 in states PAUSE and STEP
// BEHAVIOUR
//  Reset (asynchronous, takes effect immediately, including mid-STEP or mid-debounce):
//   - state=RUN, div_cnt=0, slow_clk=0, tick=0, running=1.
//   - Synchronisers and debounced levels reset to 1 (released); debounce counters reset to 0.
//  Input path, per button:
//   - 2-flop synchroniser.
//   - Debounce: count consecutive cycles where the synced level differs from the
//     debounced level; the count clears whenever the two levels match.
//   - On the cycle the count reaches DB_CYCLES, the debounced level takes the synced level.
//   - press = one-cycle pulse on a debounced 1->0 transition. Release produces no event.
//  State machine, all outputs registered:
//   - RUN: div_cnt counts 0..HALF-1. At HALF-1: div_cnt<=0 and slow_clk toggles.
//     tick=1 in the same cycle slow_clk goes 0->1.
//     pause press -> PAUSE: slow_clk<=0, div_cnt<=0. step press is ignored.
//   - PAUSE: slow_clk held at 0, div_cnt held at 0.
//     pause press -> RUN; the first rising edge of slow_clk comes HALF cycles after entry.
//     step press -> STEP: slow_clk<=1, tick<=1, div_cnt<=0.
//     pause and step pressed in the same cycle -> RUN; the step is dropped.
//   - STEP: slow_clk=1 for exactly HALF cycles, then slow_clk<=0 and -> PAUSE.
//     Both presses are ignored in STEP; no queueing.
//  Per period: exactly one tick per slow_clk rising edge, and tick is never high for 2
//   consecutive cycles. slow_clk has a 50% duty cycle with period 2*HALF while in RUN.
//  Forcing slow_clk to 0 on pause can shorten the high phase. This is allowed: the
//   consumer uses rising edges only, and every rising edge comes with a tick.
// TESTING (sim params CLK_HZ=10000, OUT_HZ=500, DEBOUNCE_MS=2 -> HALF=10, DB_CYCLES=20)
//  1. Release rst_n, no buttons -> slow_clk rises 10 cycles after release, period 20,
//     tick high 1 cycle per rising edge, running=1 throughout.
//  2. btn_pause_n low for 5 cycles (bounce) -> no state change.
//     btn_pause_n low for 30 cycles -> running=0 at 2+20+1 cycles after the fall;
//     slow_clk=0 and stays 0 for 200 cycles.
//  3. In PAUSE, press step -> slow_clk=1 for exactly 10 cycles, one tick, then 0;
//     running stays 0. Bouncing step presses during STEP -> no second pulse.
//  4. In PAUSE, press pause -> running=1, next rising edge 10 cycles later, period 20 restored.
//  5. In PAUSE, both buttons debounce in the same cycle -> RUN, with no STEP pulse.
//  6. Assert rst_n mid-STEP (slow_clk=1) -> slow_clk=0, tick=0, running=1 with no clock edge;
//     after release, behaves as in test 1.

Source files
------------

// File: rtl/chaser_tick_gen.sv
// Slow-clock and tick generator for the 5-LED chaser, with debounced pause/resume
// and single-step push-buttons. slow_clk feeds the chaser clock input directly.

module chaser_tick_gen_debounce #(
  parameter int DB_CYCLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic            sync_a;
  logic            sync_b;
  logic            level;
  logic [DB_W-1:0] db_cnt;

  // The level only moves after DB_CYCLES consecutive disagreeing samples;
  // any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
      level  <= 1'b1;
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      sync_a <= btn_n;
      sync_b <= sync_a;
      press  <= 1'b0;
      if (sync_b == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
        level  <= sync_b;
        db_cnt <= '0;
        press  <= ~sync_b;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

endmodule

// state  | meaning
// RUN    | free-running divider, slow_clk toggles every HALF cycles
// PAUSE  | slow_clk held low, waiting for resume or single-step
// STEP   | one slow_clk high phase of HALF cycles, then back to PAUSE
module chaser_tick_gen #(
  parameter int CLK_HZ      = 2_080_000,
  parameter int OUT_HZ      = 1,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_pause_n,
  input  logic btn_step_n,
  output logic slow_clk,
  output logic tick,
  output logic running
);

  localparam int HALF      = CLK_HZ / (2 * OUT_HZ);
  localparam int DB_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int DIV_W     = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PAUSE,
    ST_STEP
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic             div_last;
  logic             pause_press;
  logic             step_press;

  chaser_tick_gen_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_pause_n),
    .press (pause_press)
  );

  chaser_tick_gen_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_step_n),
    .press (step_press)
  );

  assign div_last = (div_cnt == DIV_W'(HALF - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      div_cnt  <= '0;
      slow_clk <= 1'b0;
      tick     <= 1'b0;
      running  <= 1'b1;
    end else begin
      tick <= 1'b0;
      case (state)
        ST_RUN: begin
          // Cutting the high phase short here is harmless: the chaser only uses rising edges.
          if (pause_press) begin
            state    <= ST_PAUSE;
            slow_clk <= 1'b0;
            div_cnt  <= '0;
            running  <= 1'b0;
          end else if (div_last) begin
            div_cnt  <= '0;
            slow_clk <= ~slow_clk;
            tick     <= ~slow_clk;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        ST_PAUSE: begin
          slow_clk <= 1'b0;
          div_cnt  <= '0;
          // Resume wins over a simultaneous step.
          if (pause_press) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end else if (step_press) begin
            state    <= ST_STEP;
            slow_clk <= 1'b1;
            tick     <= 1'b1;
          end
        end
        ST_STEP: begin
          if (div_last) begin
            state    <= ST_PAUSE;
            slow_clk <= 1'b0;
            div_cnt  <= '0;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: begin
          state    <= ST_RUN;
          slow_clk <= 1'b0;
          div_cnt  <= '0;
          running  <= 1'b1;
        end
      endcase
    end
  end

endmodule
